// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache with one-word blocks and a single-cycle hit
// Ports: CLK, nRST (sync, active-low); fetch side imemREN/imemaddr -> ihit/imemload; inval clears all frames;
//        memory side iREN/iaddr -> iwait/iload; hit_count/miss_count exist only when ICACHE_STATS_EN is defined.
module icache_direct_mapped #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        inval,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state;
  logic [SETS-1:0] valid;
  logic [TAGW-1:0] tags [SETS];
  logic [31:0] data [SETS];
  logic [29:0] miss_addr;
  logic [IDXW-1:0] idx, midx;
  logic [TAGW-1:0] tag;
  logic miss, fill, unused;
  always_comb begin
    idx = imemaddr[IDXW+1:2];
    tag = imemaddr[31:IDXW+2];
    midx = miss_addr[IDXW-1:0];
    ihit = nRST && state == IDLE && imemREN && valid[idx] && tags[idx] == tag;
    miss = nRST && state == IDLE && imemREN && !ihit;
    fill = nRST && state == FETCH && !iwait;
    imemload = ihit ? data[idx] : '0;
    iREN = nRST && state == FETCH;
    iaddr = iREN ? {miss_addr, 2'b00} : '0;
    unused = ^imemaddr[1:0];
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      if (miss) begin
        miss_addr <= {tag, idx};
        state <= FETCH;
      end else if (fill) begin
        state <= IDLE;
      end
      if (fill) valid[midx] <= 1'b1;
      if (inval) valid <= '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[midx] <= miss_addr[29:IDXW];
      data[midx] <= iload;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (miss && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: table-driven check of icache_direct_mapped with hand-computed vectors
module tb_icache_direct_mapped;
  logic CLK = 0, nRST = 0, imemREN = 0, inval = 0, iwait = 0;
  logic [31:0] imemaddr = 0, iload = 0;
  logic ihit, iREN;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic n, r, v, w;
    logic [31:0] a, l;
    logic eh;
    logic [31:0] ed;
    logic er;
    logic [31:0] ea;
  } vec_t;
  vec_t tv[$];
  always #5 CLK = ~CLK;
  icache_direct_mapped #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .inval(inval),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  function automatic vec_t mk(logic n, logic r, logic v, logic w, logic [31:0] a, logic [31:0] l,
                              logic eh, logic [31:0] ed, logic er, logic [31:0] ea);
    vec_t t;
    t.n = n; t.r = r; t.v = v; t.w = w; t.a = a; t.l = l;
    t.eh = eh; t.ed = ed; t.er = er; t.ea = ea;
    return t;
  endfunction
  task automatic drive(logic n, logic r, logic v, logic w, logic [31:0] a, logic [31:0] l);
    @(negedge CLK);
    nRST = n; imemREN = r; inval = v; iwait = w; imemaddr = a; iload = l;
    #1;
  endtask
`ifdef ICACHE_STATS_EN
  task automatic check_cnt(string name, logic [31:0] eh, logic [31:0] em);
    checks++;
    if (hit_count !== eh || miss_count !== em) begin
      errors++;
      $display("FAIL %s got hit_count=%h miss_count=%h expected hit_count=%h miss_count=%h",
               name, hit_count, miss_count, eh, em);
    end
  endtask
`endif
  initial begin
    tv.push_back(mk(0,0,0,0,32'h000,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(0,1,0,0,32'h040,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,1,32'h040,32'h20010005, 0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,1,32'h040,32'h20010005, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,1,32'h040,32'h20010005, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,1,32'h040,32'h20010005, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h040,32'h20010005, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        1,32'h20010005,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        1,32'h20010005,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h080,32'hAAAA0080, 0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h080,32'hAAAA0080, 0,32'h0,1,32'h080));
    tv.push_back(mk(1,1,0,0,32'h080,32'h0,        1,32'hAAAA0080,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h20010005, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        1,32'h20010005,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h100,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,1,32'h204,32'h0,        0,32'h0,1,32'h100));
    tv.push_back(mk(1,1,0,0,32'h204,32'h11110100, 0,32'h0,1,32'h100));
    tv.push_back(mk(1,1,0,1,32'h204,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h100,32'h22220204, 0,32'h0,1,32'h204));
    tv.push_back(mk(1,1,0,0,32'h100,32'h0,        1,32'h11110100,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h204,32'h0,        1,32'h22220204,0,32'h0));
    tv.push_back(mk(1,0,0,0,32'h300,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,0,0,0,32'h300,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h33330040, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h044,32'h44440044, 0,32'h0,1,32'h044));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        1,32'h33330040,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        1,32'h44440044,0,32'h0));
    tv.push_back(mk(1,0,1,0,32'h044,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h044,32'h55550040, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,1,0,32'h044,32'h66660044, 0,32'h0,1,32'h044));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h044,32'h77770044, 0,32'h0,1,32'h044));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        1,32'h77770044,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h040,32'h88880040, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h040,32'h0,        1,32'h88880040,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h100,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,1,32'h100,32'h0,        0,32'h0,1,32'h100));
    tv.push_back(mk(0,1,0,1,32'h100,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,1,32'h040,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h044,32'h99990040, 0,32'h0,1,32'h040));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,0,0,32'h044,32'h12345678, 0,32'h0,1,32'h044));
    tv.push_back(mk(1,1,0,0,32'h044,32'h0,        1,32'h12345678,0,32'h0));
    tv.push_back(mk(1,0,0,0,32'h044,32'h0,        0,32'h0,0,32'h0));
    foreach (tv[i]) begin
      drive(tv[i].n, tv[i].r, tv[i].v, tv[i].w, tv[i].a, tv[i].l);
      checks++;
      if ({ihit, imemload, iREN, iaddr} !== {tv[i].eh, tv[i].ed, tv[i].er, tv[i].ea}) begin
        errors++;
        $display("FAIL row%0d got ihit=%b imemload=%h iREN=%b iaddr=%h expected ihit=%b imemload=%h iREN=%b iaddr=%h",
                 i, ihit, imemload, iREN, iaddr, tv[i].eh, tv[i].ed, tv[i].er, tv[i].ea);
      end
    end
`ifdef ICACHE_STATS_EN
    drive(0,0,0,0,32'h0,32'h0);
    drive(0,0,0,0,32'h0,32'h0);
    check_cnt("cnt_reset", 32'd0, 32'd0);
    drive(1,1,0,0,32'h040,32'h0);
    drive(1,1,0,0,32'h040,32'h1);
    drive(1,1,0,0,32'h040,32'h0);
    drive(1,1,0,0,32'h040,32'h0);
    drive(1,1,0,0,32'h044,32'h0);
    drive(1,1,0,0,32'h044,32'h2);
    drive(1,1,0,0,32'h044,32'h0);
    drive(1,1,0,0,32'h044,32'h0);
    drive(1,1,0,0,32'h044,32'h0);
    drive(1,1,0,0,32'h080,32'h0);
    drive(1,1,0,0,32'h080,32'h3);
    drive(1,0,0,0,32'h080,32'h0);
    check_cnt("cnt_3miss_5hit", 32'd5, 32'd3);
    force dut.hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count;
    drive(1,1,0,0,32'h080,32'h0);
    drive(1,0,0,0,32'h080,32'h0);
    check_cnt("cnt_saturate", 32'hFFFF_FFFF, 32'd3);
    drive(1,0,1,0,32'h080,32'h0);
    drive(1,0,0,0,32'h080,32'h0);
    check_cnt("cnt_inval", 32'hFFFF_FFFF, 32'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
